// File: rtl/minterm_lut_pkg.sv
// rtl/minterm_lut_pkg.sv - shared types, default masks and width helpers for minterm_lut
//
// Contents:
//   sweep_state_e  sweeper FSM states (IDLE, SWEEP, DONE)
//   MASK_DEF0/1    reset minterm masks of the 4-input, 2-output configuration
//   mask_width()   mask bits for a given input count (2**n_in)
//   cnt_width()    ones-count width able to hold a full count (n_in+1)
//   sel_width()    config select width, never below one bit

package minterm_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_e;

    // Output 0: minterms {4,5,6,7,11,12,13}; output 1: minterms {1,2,4,5}.
    localparam logic [15:0] MASK_DEF0 = 16'h38F0;
    localparam logic [15:0] MASK_DEF1 = 16'h0036;

    function automatic int mask_width(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int cnt_width(input int n_in);
        return n_in + 1;
    endfunction

    function automatic int sel_width(input int n_out);
        return (n_out > 1) ? $clog2(n_out) : 1;
    endfunction

endpackage

// File: rtl/minterm_lut_sweeper.sv
// rtl/minterm_lut_sweeper.sv - exhaustive sweep FSM counting true minterms per output
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        begin a sweep (honoured only in IDLE)
//   masks_i        current mask array, output k at index k
//   idle_o         FSM is in IDLE (evaluation/config allowed)
//   busy_o         registered: sweep in progress
//   done_o         registered: one-cycle pulse when cnt_o is updated
//   cnt_o          ones-count per output, slice k = output k
//   step_valid_o   a sweep step is taken this cycle
//   step_idx_o     minterm index examined by the current step

module minterm_lut_sweeper
    import minterm_lut_pkg::*;
#(
    parameter  int N_IN   = 4,
    parameter  int N_OUT  = 2,
    localparam int MASK_W = mask_width(N_IN),
    localparam int CNT_W  = cnt_width(N_IN)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic [N_OUT-1:0][MASK_W-1:0]   masks_i,
    output logic                           idle_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [N_OUT*CNT_W-1:0]         cnt_o,
    output logic                           step_valid_o,
    output logic [N_IN-1:0]                step_idx_o
);

    sweep_state_e                   state_q;
    logic [N_IN-1:0]                idx_q;
    logic [N_OUT-1:0][CNT_W-1:0]    acc_q;
    logic [N_OUT-1:0][CNT_W-1:0]    acc_d;
    logic [N_OUT-1:0][CNT_W-1:0]    cnt_q;
    logic                           busy_q;
    logic                           done_q;

    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < N_OUT; k++) begin
            acc_d[k] = acc_q[k] + CNT_W'(masks_i[k][idx_q]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_SWEEP;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    // The last step publishes the sum including its own minterm,
                    // so done/count appear right as busy drops.
                    if (idx_q == '1) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= acc_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign idle_o       = (state_q == ST_IDLE);
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign cnt_o        = cnt_q;
    assign step_valid_o = (state_q == ST_SWEEP);
    assign step_idx_o   = idx_q;

endmodule

// File: rtl/minterm_lut.sv
// rtl/minterm_lut.sv - registered sum-of-minterms evaluator with writable masks and self-count sweep
//
// Optional build macro: MINTERM_LUT_SWEEP_STREAM_EN
//   defined   - each sweep step also emits out_vec = f(idx) with out_valid
//   undefined - sweep leaves out_vec/out_valid untouched
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_vec         input combination, MSB is variable A
//   in_valid       evaluate in_vec (IDLE only, loses to sweep_start)
//   out_vec        registered function values, bit k = output k
//   out_valid      out_vec strobe, one cycle after the accepted input
//   cfg_we         mask write strobe (IDLE only)
//   cfg_sel        output index to write
//   cfg_mask       new mask, bit i = minterm i
//   cfg_err        one-cycle pulse for a rejected write
//   sweep_start    begin exhaustive sweep
//   sweep_busy     sweep in progress
//   sweep_done     one-cycle pulse when sweep_cnt is updated
//   sweep_cnt      ones-count per output, slice k = output k

module minterm_lut
    import minterm_lut_pkg::*;
#(
    parameter  int N_IN  = 4,
    parameter  int N_OUT = 2,
    parameter  logic [N_OUT*mask_width(N_IN)-1:0] DEFAULT_MASKS = {MASK_DEF1, MASK_DEF0},
    localparam int MASK_W = mask_width(N_IN),
    localparam int CNT_W  = cnt_width(N_IN),
    localparam int SEL_W  = sel_width(N_OUT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_IN-1:0]            in_vec,
    input  logic                       in_valid,
    output logic [N_OUT-1:0]           out_vec,
    output logic                       out_valid,
    input  logic                       cfg_we,
    input  logic [SEL_W-1:0]           cfg_sel,
    input  logic [MASK_W-1:0]          cfg_mask,
    output logic                       cfg_err,
    input  logic                       sweep_start,
    output logic                       sweep_busy,
    output logic                       sweep_done,
    output logic [N_OUT*CNT_W-1:0]     sweep_cnt
);

    logic [N_OUT-1:0][MASK_W-1:0]  masks_q;
    logic [N_OUT-1:0]              out_vec_q;
    logic                          out_valid_q;
    logic                          cfg_err_q;

    logic                          idle;
    logic                          step_valid;
    logic [N_IN-1:0]               step_idx;
    logic                          accept_eval;
    logic                          sel_oob;
    logic [N_OUT-1:0]              eval_vec;
    logic [N_OUT-1:0]              step_vec;

    minterm_lut_sweeper #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_sweeper (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (sweep_start),
        .masks_i      (masks_q),
        .idle_o       (idle),
        .busy_o       (sweep_busy),
        .done_o       (sweep_done),
        .cnt_o        (sweep_cnt),
        .step_valid_o (step_valid),
        .step_idx_o   (step_idx)
    );

    // A sweep request in the same cycle takes priority and swallows the input.
    assign accept_eval = in_valid && idle && !sweep_start;
    assign sel_oob     = (int'(cfg_sel) >= N_OUT);

    always_comb begin
        eval_vec = '0;
        step_vec = '0;
        for (int k = 0; k < N_OUT; k++) begin
            eval_vec[k] = masks_q[k][in_vec];
            step_vec[k] = masks_q[k][step_idx];
        end
    end

    // Evaluation reads masks_q before this edge's write lands, so a
    // simultaneous config write only affects later evaluations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept_eval) begin
                out_vec_q   <= eval_vec;
                out_valid_q <= 1'b1;
            end
`ifdef MINTERM_LUT_SWEEP_STREAM_EN
            else if (step_valid) begin
                out_vec_q   <= step_vec;
                out_valid_q <= 1'b1;
            end
`endif
        end
    end

`ifndef MINTERM_LUT_SWEEP_STREAM_EN
    logic unused_step;
    assign unused_step = ^{step_valid, step_vec};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            masks_q   <= DEFAULT_MASKS;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            if (cfg_we) begin
                if (!idle || sel_oob) begin
                    cfg_err_q <= 1'b1;
                end else begin
                    masks_q[cfg_sel] <= cfg_mask;
                end
            end
        end
    end

    assign out_vec   = out_vec_q;
    assign out_valid = out_valid_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_minterm_lut.sv
// tb/tb_minterm_lut.sv - scoreboard bench for minterm_lut

module tb_minterm_lut;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_vec;
    logic        in_valid;
    logic [1:0]  out_vec;
    logic        out_valid;
    logic        cfg_we;
    logic [0:0]  cfg_sel;
    logic [15:0] cfg_mask;
    logic        cfg_err;
    logic        sweep_start;
    logic        sweep_busy;
    logic        sweep_done;
    logic [9:0]  sweep_cnt;

    logic [3:0]  in3_vec;
    logic        in3_valid;
    logic [2:0]  out3_vec;
    logic        out3_valid;
    logic        cfg3_we;
    logic [1:0]  cfg3_sel;
    logic [15:0] cfg3_mask;
    logic        cfg3_err;
    logic        sw3_start;
    logic        sw3_busy;
    logic        sw3_done;
    logic [14:0] sw3_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  exp_q[$];
    logic [15:0] mdl [2];

    minterm_lut dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_vec      (in_vec),
        .in_valid    (in_valid),
        .out_vec     (out_vec),
        .out_valid   (out_valid),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_mask    (cfg_mask),
        .cfg_err     (cfg_err),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .sweep_cnt   (sweep_cnt)
    );

    minterm_lut #(
        .N_IN          (4),
        .N_OUT         (3),
        .DEFAULT_MASKS ({16'hAAAA, 16'h0036, 16'h38F0})
    ) dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_vec      (in3_vec),
        .in_valid    (in3_valid),
        .out_vec     (out3_vec),
        .out_valid   (out3_valid),
        .cfg_we      (cfg3_we),
        .cfg_sel     (cfg3_sel),
        .cfg_mask    (cfg3_mask),
        .cfg_err     (cfg3_err),
        .sweep_start (sw3_start),
        .sweep_busy  (sw3_busy),
        .sweep_done  (sw3_done),
        .sweep_cnt   (sw3_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] f(input int i);
        return {mdl[1][i], mdl[0][i]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
            else                   check("out_vec", out_vec, exp_q.pop_front());
        end
    end

    task automatic drive_eval(input logic [3:0] v);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_vec   = v;
        exp_q.push_back(f(int'(v)));
    endtask

    task automatic drive_idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input int e0, input int e1,
                             input bit with_eval, input bit poke);
        int busy_n;
        int done_at;
        @(posedge clk); #1;
        sweep_start = 1'b1;
        in_valid    = with_eval;
        in_vec      = 4'd5;
`ifdef MINTERM_LUT_SWEEP_STREAM_EN
        for (int i = 0; i < 16; i++) exp_q.push_back(f(i));
`endif
        @(posedge clk); #1;
        sweep_start = 1'b0;
        in_valid    = 1'b0;
        busy_n  = 0;
        done_at = 0;
        for (int c = 1; c <= 40 && done_at == 0; c++) begin
            @(negedge clk);
            if (sweep_busy) busy_n++;
            if (sweep_done) begin
                done_at = c;
                check({tag, "_busy_at_done"}, sweep_busy, 0);
            end
            if (poke && c == 4) begin
                cfg_we   = 1'b1;
                cfg_sel  = 1'b0;
                cfg_mask = 16'h0000;
                in_valid = 1'b1;
                in_vec   = 4'd5;
            end
            if (poke && c == 5) begin
                check({tag, "_cfg_err_busy"}, cfg_err, 1);
                cfg_we   = 1'b0;
                in_valid = 1'b0;
            end
        end
        check({tag, "_busy_cycles"}, busy_n, 16);
        check({tag, "_done_cycle"}, done_at, 17);
        check({tag, "_cnt0"}, sweep_cnt[4:0], e0);
        check({tag, "_cnt1"}, sweep_cnt[9:5], e1);
        @(negedge clk);
        check({tag, "_done_pulse"}, sweep_done, 0);
        check({tag, "_cnt_hold"}, sweep_cnt, {e1[4:0], e0[4:0]});
    endtask

    initial begin
        rst_n = 1'b0;
        in_vec = '0; in_valid = 1'b0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_mask = '0; sweep_start = 1'b0;
        in3_vec = '0; in3_valid = 1'b0;
        cfg3_we = 1'b0; cfg3_sel = '0; cfg3_mask = '0; sw3_start = 1'b0;
        mdl[0] = 16'h38F0;
        mdl[1] = 16'h0036;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_vec", out_vec, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_busy", sweep_busy, 0);
        check("rst_done", sweep_done, 0);
        check("rst_cnt", sweep_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // consecutive evaluations with default masks
        drive_eval(4'b0101);
        drive_eval(4'b1011);
        drive_eval(4'b0000);
        drive_eval(4'b0010);
        drive_idle();
        repeat (3) @(negedge clk);
        check("t1_drained", exp_q.size(), 0);

        // default sweep; simultaneous in_valid must be dropped
        run_sweep("t2", 7, 4, 1'b1, 1'b0);

        // write output 1 to all-ones together with an evaluation using the old mask
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_mask = 16'hFFFF;
        in_valid = 1'b1; in_vec = 4'b0101;
        exp_q.push_back(f(5));
        mdl[1] = 16'hFFFF;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        in_vec = 4'b1111;
        exp_q.push_back(f(15));
        @(negedge clk);
        check("t3_cfg_err_ok", cfg_err, 0);
        drive_idle();
        run_sweep("t3", 7, 16, 1'b0, 1'b0);

        // write and evaluation attempts during sweep are rejected
        run_sweep("t4", 7, 16, 1'b0, 1'b1);
        drive_eval(4'b1111);
        drive_idle();
        repeat (2) @(negedge clk);

        // out-of-range select on the 3-output instance
        @(negedge clk);
        cfg3_we = 1'b1; cfg3_sel = 2'd3; cfg3_mask = 16'h0000;
        @(negedge clk);
        check("t4_err_sel_oob", cfg3_err, 1);
        cfg3_we = 1'b0; in3_valid = 1'b1; in3_vec = 4'd1;
        @(negedge clk);
        check("t4_oob_kept_mask", out3_vec, 3'b110);
        check("t4_oob_valid", out3_valid, 1);
        check("t4_err_cleared", cfg3_err, 0);
        in3_valid = 1'b0;
        cfg3_we = 1'b1; cfg3_sel = 2'd2; cfg3_mask = 16'h0000;
        @(negedge clk);
        check("t4_err_sel_ok", cfg3_err, 0);
        cfg3_we = 1'b0; in3_valid = 1'b1; in3_vec = 4'd1;
        @(negedge clk);
        check("t4_sel2_written", out3_vec, 3'b010);
        in3_valid = 1'b0;

        // reset in the middle of a sweep
        @(posedge clk); #1;
        sweep_start = 1'b1;
`ifdef MINTERM_LUT_SWEEP_STREAM_EN
        for (int i = 0; i < 16; i++) exp_q.push_back(f(i));
`endif
        @(posedge clk); #1;
        sweep_start = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_busy_before", sweep_busy, 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_busy_abort", sweep_busy, 0);
        check("t5_cnt_abort", sweep_cnt, 0);
        check("t5_valid_abort", out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mdl[0] = 16'h38F0;
        mdl[1] = 16'h0036;
        run_sweep("t5", 7, 4, 1'b0, 1'b0);
        drive_eval(4'b1111);
        drive_eval(4'b0101);
        drive_idle();

        repeat (4) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
